// File: rtl/elevator_scan_if.sv
// Call buttons, motor/door commands and status lamps of one elevator car.
// The controller connects through the slave modport; the hall/car panel side uses master.
interface elevator_scan_if #(
    parameter int N_FLOORS = 10,
    parameter int FW       = $clog2(N_FLOORS)
) ();
    logic [N_FLOORS-1:0] button_up;
    logic [N_FLOORS-1:0] button_down;
    logic [N_FLOORS-1:0] button_floor;
    logic                door_open;
    logic                go_up;
    logic                go_down;
    logic [FW-1:0]       floor_number;
    logic                dir_up;
    logic [N_FLOORS-1:0] pend_up;
    logic [N_FLOORS-1:0] pend_down;
    logic [N_FLOORS-1:0] pend_car;

    modport master (
        output button_up, button_down, button_floor,
        input  door_open, go_up, go_down, floor_number, dir_up,
        input  pend_up, pend_down, pend_car
    );

    modport slave (
        input  button_up, button_down, button_floor,
        output door_open, go_up, go_down, floor_number, dir_up,
        output pend_up, pend_down, pend_car
    );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN (collector) elevator controller: latches hall/car calls and
// serves them in the current direction while any request lies ahead.
module elevator_scan_ctrl #(
    parameter int N_FLOORS    = 10,
    parameter int DOOR_CYCLES = 8,
    parameter int MOVE_CYCLES = 4,
    parameter int FW          = $clog2(N_FLOORS)
) (
    input logic             clk,
    input logic             rst_n,
    elevator_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DOOR, MOVE_UP, MOVE_DOWN} state_t;

    localparam int CNT_MAX = (DOOR_CYCLES > MOVE_CYCLES) ? DOOR_CYCLES : MOVE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] ONE       = N_FLOORS'(1);
    localparam logic [N_FLOORS-1:0] UP_MASK   = ~(ONE << (N_FLOORS - 1));
    localparam logic [N_FLOORS-1:0] DOWN_MASK = ~ONE;

    state_t              state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic                dir_q, dir_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [N_FLOORS-1:0] pend_down_q, pend_down_d;
    logic [N_FLOORS-1:0] pend_car_q, pend_car_d;

    // Floor being evaluated: the next floor during a move, else the current one.
    logic [FW-1:0]       ef;
    logic [N_FLOORS-1:0] ef_hot, all_pend, btn_up, btn_down;
    logic here_car, here_up, here_down, btn_car, btn_hup, btn_hdown;
    logic above, below, ahead, behind, svc, btn_svc;
    logic here_dir, here_opp, btn_dir, btn_opp;

    assign btn_up   = bus.button_up & UP_MASK;
    assign btn_down = bus.button_down & DOWN_MASK;
    assign all_pend = pend_up_q | pend_down_q | pend_car_q;

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        ef = floor_q;
        if (state_q == MOVE_UP)        ef = floor_q + 1'b1;
        else if (state_q == MOVE_DOWN) ef = floor_q - 1'b1;
        ef_hot    = '0;
        here_car  = 1'b0;
        here_up   = 1'b0;
        here_down = 1'b0;
        btn_car   = 1'b0;
        btn_hup   = 1'b0;
        btn_hdown = 1'b0;
        above     = 1'b0;
        below     = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) == ef) begin
                ef_hot[i] = 1'b1;
                here_car  = pend_car_q[i];
                here_up   = pend_up_q[i];
                here_down = pend_down_q[i];
                btn_car   = bus.button_floor[i];
                btn_hup   = btn_up[i];
                btn_hdown = btn_down[i];
            end else if (FW'(i) > ef) begin
                above = above | all_pend[i];
            end else begin
                below = below | all_pend[i];
            end
        end
        ahead    = dir_q ? above : below;
        behind   = dir_q ? below : above;
        here_dir = dir_q ? here_up : here_down;
        here_opp = dir_q ? here_down : here_up;
        btn_dir  = dir_q ? btn_hup : btn_hdown;
        btn_opp  = dir_q ? btn_hdown : btn_hup;
        svc      = here_car | here_dir | (here_opp & ~ahead);
        btn_svc  = btn_car | btn_dir | (btn_opp & ~ahead);
    end

    logic                serve, in_door;
    logic [N_FLOORS-1:0] clr_up, clr_down, clr_car, sup_up, sup_down, sup_car;

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        serve   = 1'b0;
        in_door = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (svc) begin
                    state_d = DOOR;
                    serve   = 1'b1;
                    cnt_d   = DOOR_LOAD;
                end else if (ahead) begin
                    state_d = dir_q ? MOVE_UP : MOVE_DOWN;
                    cnt_d   = MOVE_LOAD;
                end else if (behind) begin
                    dir_d   = ~dir_q;
                    state_d = dir_q ? MOVE_DOWN : MOVE_UP;
                    cnt_d   = MOVE_LOAD;
                end
            end
            DOOR: begin
                in_door = 1'b1;
                if (btn_svc)            cnt_d   = DOOR_LOAD;
                else if (cnt_q == '0)   state_d = IDLE;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    floor_d = ef;
                    if (svc) begin
                        state_d = DOOR;
                        serve   = 1'b1;
                        cnt_d   = DOOR_LOAD;
                    end else if (ahead) begin
                        cnt_d   = MOVE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Serving clears the car call and the hall call in the travel direction;
        // with nothing ahead the car turns round and also takes the opposite call.
        clr_car  = serve ? ef_hot : '0;
        clr_up   = (serve & dir_q)  ? ef_hot : '0;
        clr_down = (serve & ~dir_q) ? ef_hot : '0;
        if (serve && !ahead) begin
            dir_d = ~dir_q;
            if (dir_q) clr_down = ef_hot;
            else       clr_up   = ef_hot;
        end

        // With the door open, presses that would be served here only extend the stop.
        sup_car  = in_door ? ef_hot : '0;
        sup_up   = (in_door & (dir_q | ~ahead))  ? ef_hot : '0;
        sup_down = (in_door & (~dir_q | ~ahead)) ? ef_hot : '0;

        pend_up_d   = (pend_up_q   | (btn_up           & ~sup_up))   & ~clr_up;
        pend_down_d = (pend_down_q | (btn_down         & ~sup_down)) & ~clr_down;
        pend_car_d  = (pend_car_q  | (bus.button_floor & ~sup_car))  & ~clr_car;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            dir_q       <= 1'b1;
            cnt_q       <= '0;
            pend_up_q   <= '0;
            pend_down_q <= '0;
            pend_car_q  <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            pend_up_q   <= pend_up_d;
            pend_down_q <= pend_down_d;
            pend_car_q  <= pend_car_d;
        end
    end

    assign bus.door_open    = (state_q == DOOR);
    assign bus.go_up        = (state_q == MOVE_UP);
    assign bus.go_down      = (state_q == MOVE_DOWN);
    assign bus.floor_number = floor_q;
    assign bus.dir_up       = dir_q;
    assign bus.pend_up      = pend_up_q;
    assign bus.pend_down    = pend_down_q;
    assign bus.pend_car     = pend_car_q;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (10 floors, 8-cycle door, 4-cycle hop):
// idle after reset, local call, single trip, SCAN order, end floors, door hold, reset.
module tb_elevator_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    elevator_scan_if #(.N_FLOORS(10)) bus ();

    elevator_scan_ctrl #(.N_FLOORS(10), .DOOR_CYCLES(8), .MOVE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and confirm the commands stay exclusive.
    task automatic tick();
        int act;
        @(negedge clk);
        act = int'(bus.door_open) + int'(bus.go_up) + int'(bus.go_down);
        check("exclusive", 32'(act <= 1), 32'd1);
    endtask

    task automatic wait_door(input string tag);
        int n;
        n = 0;
        while (bus.door_open === 1'b1 && n < 100) begin tick(); n++; end
        while (bus.door_open !== 1'b1 && n < 100) begin tick(); n++; end
        check({tag, "_door"}, 32'(bus.door_open), 32'd1);
    endtask

    task automatic wait_closed(input string tag);
        int n;
        n = 0;
        while (bus.door_open === 1'b1 && n < 50) begin tick(); n++; end
        check({tag, "_closed"}, 32'(bus.door_open), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.button_up    = '0;
        bus.button_down  = '0;
        bus.button_floor = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_door",  32'(bus.door_open), 32'd0);
            check("idle_up",    32'(bus.go_up), 32'd0);
            check("idle_down",  32'(bus.go_down), 32'd0);
            check("idle_floor", 32'(bus.floor_number), 32'd0);
            check("idle_dir",   32'(bus.dir_up), 32'd1);
            check("idle_pend",  32'(bus.pend_up | bus.pend_down | bus.pend_car), 32'd0);
        end

        // Local call at floor 0: door opens two edges after the press for 8 cycles.
        bus.button_up = 10'b0000000001;
        tick();
        bus.button_up = '0;
        check("local_latched", 32'(bus.pend_up), 32'h001);
        check("local_not_yet", 32'(bus.door_open), 32'd0);
        tick();
        check("local_open",    32'(bus.door_open), 32'd1);
        check("local_cleared", 32'(bus.pend_up), 32'd0);
        check("local_dir",     32'(bus.dir_up), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("local_hold", 32'(bus.door_open), 32'd1);
            check("local_nomove", 32'(bus.go_up | bus.go_down), 32'd0);
        end
        tick();
        check("local_close", 32'(bus.door_open), 32'd0);

        // Single trip 0 -> 3: go_up for 12 cycles, floor steps every 4.
        bus.button_floor = 10'b0000001000;
        tick();
        bus.button_floor = '0;
        check("trip_latched", 32'(bus.pend_car), 32'h008);
        check("trip_wait",    32'(bus.go_up), 32'd0);
        tick();
        check("trip_dir", 32'(bus.dir_up), 32'd1);
        for (int i = 0; i < 12; i++) begin
            check("trip_go_up", 32'(bus.go_up), 32'd1);
            check("trip_floor", 32'(bus.floor_number), 32'(i / 4));
            tick();
        end
        check("trip_open",   32'(bus.door_open), 32'd1);
        check("trip_stop",   32'(bus.go_up), 32'd0);
        check("trip_arrive", 32'(bus.floor_number), 32'd3);
        check("trip_served", 32'(bus.pend_car), 32'd0);
        check("trip_turn",   32'(bus.dir_up), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("trip_hold", 32'(bus.door_open), 32'd1);
        end
        tick();
        check("trip_close", 32'(bus.door_open), 32'd0);

        // SCAN order: from floor 3 heading to 7 with down@6 and up@2 pending.
        bus.button_floor = 10'b0010000000;
        tick();
        bus.button_floor = '0;
        tick();
        check("scan_start", 32'(bus.go_up), 32'd1);
        bus.button_down = 10'b0001000000;
        bus.button_up   = 10'b0000000100;
        tick();
        bus.button_down = '0;
        bus.button_up   = '0;
        check("scan_pend_car",  32'(bus.pend_car), 32'h080);
        check("scan_pend_down", 32'(bus.pend_down), 32'h040);
        check("scan_pend_up",   32'(bus.pend_up), 32'h004);
        repeat (7) tick();
        check("scan_at5",    32'(bus.floor_number), 32'd5);
        check("scan_at5_up", 32'(bus.go_up), 32'd1);
        check("scan_at5_dir", 32'(bus.dir_up), 32'd1);
        wait_door("scan_first");
        check("scan_stop7",     32'(bus.floor_number), 32'd7);
        check("scan_dir7",      32'(bus.dir_up), 32'd0);
        check("scan_kept_down", 32'(bus.pend_down), 32'h040);
        check("scan_car_clr",   32'(bus.pend_car), 32'd0);
        wait_door("scan_second");
        check("scan_stop6",    32'(bus.floor_number), 32'd6);
        check("scan_down_clr", 32'(bus.pend_down), 32'd0);
        check("scan_dir6",     32'(bus.dir_up), 32'd0);
        wait_door("scan_third");
        check("scan_stop2",  32'(bus.floor_number), 32'd2);
        check("scan_up_clr", 32'(bus.pend_up), 32'd0);
        check("scan_dir2",   32'(bus.dir_up), 32'd1);
        wait_closed("scan_end");

        // End-floor buttons that do not exist are never latched.
        bus.button_down = 10'b0000000001;
        bus.button_up   = 10'b1000000000;
        tick();
        bus.button_down = '0;
        bus.button_up   = '0;
        check("end_up",   32'(bus.pend_up), 32'd0);
        check("end_down", 32'(bus.pend_down), 32'd0);
        repeat (5) tick();
        check("end_idle",  32'(bus.go_up | bus.go_down | bus.door_open), 32'd0);
        check("end_floor", 32'(bus.floor_number), 32'd2);

        // Door held open by a same-floor press.
        bus.button_floor = 10'b0000000100;
        tick();
        bus.button_floor = '0;
        tick();
        check("hold_open", 32'(bus.door_open), 32'd1);
        repeat (3) tick();
        bus.button_floor = 10'b0000000100;
        tick();
        bus.button_floor = '0;
        check("hold_not_latched", 32'(bus.pend_car), 32'd0);
        check("hold_still_open",  32'(bus.door_open), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("hold_extended", 32'(bus.door_open), 32'd1);
        end
        tick();
        check("hold_close", 32'(bus.door_open), 32'd0);

        // Reset mid-move drops the car back to floor 0 and loses requests.
        bus.button_floor = 10'b0100000000;
        tick();
        bus.button_floor = '0;
        tick();
        check("mid_go_up", 32'(bus.go_up), 32'd1);
        repeat (4) tick();
        bus.button_up = 10'b0000100000;
        tick();
        bus.button_up = '0;
        check("mid_floor", 32'(bus.floor_number), 32'd3);
        check("mid_pend",  32'(bus.pend_up), 32'h020);
        rst_n = 1'b0;
        tick();
        check("rst_go_up", 32'(bus.go_up), 32'd0);
        check("rst_floor", 32'(bus.floor_number), 32'd0);
        check("rst_pend",  32'(bus.pend_up | bus.pend_down | bus.pend_car), 32'd0);
        check("rst_dir",   32'(bus.dir_up), 32'd1);
        check("rst_door",  32'(bus.door_open), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(bus.go_up | bus.go_down | bus.door_open), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
